uart_dec_counter_loader: RTL and testbench
==========================================

Name: uart_dec_counter_loader

Overview:
- Parses decimal ASCII lines popped from the UART RX FIFO and converts them to a 14-bit binary value.
- The output drives the `counter[13:0]` input of the FND display top.
- It is the producer side of the counter/display interface: the display splits binary into digits, and this block assembles digits back into binary.
- Sits between the RX FIFO read port and the display top.

Parameters:
MAX_DIGITS, 4, maximum accepted decimal digits per line
MAX_VALUE, 9999, largest committed value; larger values are rejected at commit

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  RX FIFO read data; valid the cycle after rx_pop
rx_empty  input  1  RX FIFO empty flag
rx_pop  output  1  RX FIFO read strobe, one cycle per character
counter  output  14  last committed value, held between commits
counter_valid  output  1  one-cycle pulse when counter updates
err  output  1  one-cycle pulse when a line is rejected

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is sampled synchronously.
  - Reset values: counter=0, counter_valid=0, err=0, rx_pop=0.
  - Reset also clears acc=0, digit_cnt=0, line_err=0 and sets state=IDLE.
- FSM:
  - IDLE: if !rx_empty, assert rx_pop for exactly one cycle and go to READ. Otherwise stay.
  - READ: sample rx_data, classify and process the character, return to IDLE.
  - Throughput is one character per 2 cycles.
  - rx_pop is never asserted while rx_empty=1 and never in two consecutive cycles.
- Character handling in READ:
  - Digit 0x30-0x39:
    - If digit_cnt<MAX_DIGITS: acc <= acc*10 + (rx_data-0x30) and digit_cnt++.
    - The multiply-add is computed in 17 bits and truncated to 14 bits; truncation is safe because MAX_DIGITS=4 bounds acc at 9999.
    - Otherwise (too many digits): line_err <= 1 and acc is unchanged.
  - Terminator 0x0D or 0x0A:
    - If digit_cnt==0 and line_err==0: ignore. This makes CRLF and blank lines silent.
    - Else if line_err==1 or acc>MAX_VALUE: pulse err; counter is unchanged.
    - Else: counter <= acc and pulse counter_valid.
    - In every case, clear acc, digit_cnt and line_err.
  - Any other byte: line_err <= 1; the rest of the line is consumed until a terminator.
- Output timing:
  - counter and counter_valid update on the same edge, the edge ending READ of the terminator.
  - Latency is 2 cycles from the IDLE cycle that sees the terminator with !rx_empty.
  - counter_valid and err are mutually exclusive and never assert for 2 consecutive cycles.
- Reset mid-line: any partial line is discarded; the next line is parsed from a clean state.

Optional Feature:
- Macro UART_DEC_ECHO_EN.
- When defined, adds the following ports:
  - tx_data  output  8  echoed character
  - tx_push  output  1  TX FIFO write strobe
  - tx_full  input  1  TX FIFO full flag
- Echo behaviour:
  - In READ, every popped character is written to the TX FIFO (tx_data=rx_data, tx_push=1 for one cycle).
  - If tx_full=1 during READ, hold in READ without consuming (acc/line state unchanged) until tx_full=0, then push and process in the same cycle.
  - Reset values: tx_push=0, tx_data=0.
- When not defined: no TX ports, no echo, and READ always completes in one cycle.

Test Plan:
- Bytes "1234\r" with rx_empty gaps of 0 and of 7 cycles -> counter=1234, exactly one counter_valid pulse, err never asserts; rx_pop count = 5.
- "42\r\n" then "\r\n" -> counter=42 with one counter_valid pulse; the trailing LF and blank line produce no pulses.
- "12345\r" -> err pulse at CR, counter keeps its previous value (1234); a following "7\r" -> counter=7.
- "12a3\r" -> err pulse at CR, no counter_valid; a following "0\r" -> counter=0 with counter_valid pulse.
- "98" then rst for 1 cycle, then "5\r" -> counter=0 after reset, then counter=5; the partial line is lost.
- With UART_DEC_ECHO_EN: "61\r" with tx_full held high 4 cycles on the '1' -> tx_push emits 0x36,0x31,0x0D in order; rx_pop stalls; counter=61.

Source files
------------

// File: rtl/uart_dec_counter_loader_if.sv
// Purpose: bundles the RX FIFO read port, the counter/display output and the optional TX echo port.
// Latency: none; this interface only carries wires.
// Backpressure: rx_empty gates rx_pop; with UART_DEC_ECHO_EN defined, tx_full stalls the loader.
interface uart_dec_counter_loader_if;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_pop;
    logic [13:0] counter;
    logic        counter_valid;
    logic        err;
`ifdef UART_DEC_ECHO_EN
    logic [7:0]  tx_data;
    logic        tx_push;
    logic        tx_full;

    modport master (
        input  rx_data, rx_empty, tx_full,
        output rx_pop, counter, counter_valid, err, tx_data, tx_push
    );
    modport slave (
        output rx_data, rx_empty, tx_full,
        input  rx_pop, counter, counter_valid, err, tx_data, tx_push
    );
`else
    modport master (
        input  rx_data, rx_empty,
        output rx_pop, counter, counter_valid, err
    );
    modport slave (
        output rx_data, rx_empty,
        input  rx_pop, counter, counter_valid, err
    );
`endif
endinterface

// File: rtl/uart_dec_counter_loader.sv
// Purpose: turns CR/LF-terminated decimal ASCII lines from the RX FIFO into a 14-bit counter value.
// Latency: 2 cycles from the IDLE cycle that sees the terminator available to counter/counter_valid.
// Backpressure: pops only when rx_empty=0, one character every 2 cycles; UART_DEC_ECHO_EN adds a TX echo where tx_full holds READ.
module uart_dec_counter_loader #(
    parameter int MAX_DIGITS = 4,
    parameter int MAX_VALUE  = 9999
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_dec_counter_loader_if.master  bus
);
    localparam int CW = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            consume;
    logic [13:0]     acc;
    logic [CW-1:0]   digit_cnt;
    logic            line_err;
    logic            is_digit;
    logic            is_term;
    logic [16:0]     mac;

    assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_term  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    // For ASCII digits the low nibble is exactly the digit value, i.e. rx_data - 0x30.
    // acc never exceeds 9999 while digit_cnt is bounded, so the 14-bit truncation loses nothing.
    assign mac = (17'(acc) * 17'd10) + 17'(bus.rx_data[3:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, FIFO pop strobe and the "process this character now" qualifier.
    always_comb begin
        state_next = state;
        bus.rx_pop = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.rx_empty && !rst) begin
                    bus.rx_pop = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
`ifdef UART_DEC_ECHO_EN
                // The FIFO keeps rx_data stable until the next pop, so waiting here is safe.
                if (!bus.tx_full) begin
                    consume    = 1'b1;
                    state_next = IDLE;
                end
`else
                consume    = 1'b1;
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line parser datapath: accumulate digits, commit or reject on terminator, emit pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc               <= '0;
            digit_cnt         <= '0;
            line_err          <= 1'b0;
            bus.counter       <= '0;
            bus.counter_valid <= 1'b0;
            bus.err           <= 1'b0;
`ifdef UART_DEC_ECHO_EN
            bus.tx_push       <= 1'b0;
            bus.tx_data       <= '0;
`endif
        end else begin
            bus.counter_valid <= 1'b0;
            bus.err           <= 1'b0;
`ifdef UART_DEC_ECHO_EN
            bus.tx_push       <= 1'b0;
`endif
            if (consume) begin
`ifdef UART_DEC_ECHO_EN
                bus.tx_push <= 1'b1;
                bus.tx_data <= bus.rx_data;
`endif
                if (is_digit) begin
                    if (digit_cnt < CW'(MAX_DIGITS)) begin
                        acc       <= mac[13:0];
                        digit_cnt <= digit_cnt + CW'(1);
                    end else begin
                        line_err <= 1'b1;
                    end
                end else if (is_term) begin
                    // A terminator with nothing before it (CRLF tail, blank line) is silent.
                    if ((digit_cnt != '0) || line_err) begin
                        if (line_err || ({18'd0, acc} > 32'(MAX_VALUE))) begin
                            bus.err <= 1'b1;
                        end else begin
                            bus.counter       <= acc;
                            bus.counter_valid <= 1'b1;
                        end
                    end
                    acc       <= '0;
                    digit_cnt <= '0;
                    line_err  <= 1'b0;
                end else begin
                    line_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_dec_counter_loader.sv
// Purpose: scoreboard bench for uart_dec_counter_loader with directed lines and random lines.
// Latency: expected pulses are queued at stimulus time and consumed whenever the DUT pulses.
// Backpressure: the bench FIFO model honours rx_pop/rx_empty with random gaps; echo builds also toggle tx_full.
module tb_uart_dec_counter_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_dec_counter_loader_if bus ();

    uart_dec_counter_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [7:0] b;
        int         gap;
    } rx_ent_t;

    typedef struct {
        bit is_err;
        int val;
    } exp_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    rx_ent_t    rx_q[$];
    exp_t       exp_q[$];
    logic [7:0] echo_q[$];
    int         m_digits[$];
    bit         m_bad;
    int         m_committed;
    int         n_checks = 0;
    int         n_pass = 0;
    int         pops = 0;
    int         bytes_sent = 0;
    int         pops_mark = 0;
    int         bytes_mark = 0;

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Reference model: a line is a list of digit values plus a "bad" flag; judged at the terminator.
    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) begin
            m_digits.push_back(int'(b) - 48);
        end else if (b == CR || b == LF) begin
            if (m_digits.size() != 0 || m_bad) begin
                int v;
                bit rej;
                v   = 0;
                rej = m_bad || (m_digits.size() > 4);
                if (!rej) begin
                    foreach (m_digits[i]) v = v * 10 + m_digits[i];
                    rej = (v > 9999);
                end
                if (rej) begin
                    exp_q.push_back('{1'b1, m_committed});
                end else begin
                    m_committed = v;
                    exp_q.push_back('{1'b0, v});
                end
            end
            m_digits.delete();
            m_bad = 1'b0;
        end else begin
            m_bad = 1'b1;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_q.push_back('{b, gap});
        bytes_sent++;
        model_byte(b);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    // Wait for the FIFO to empty and the DUT to settle, then check pops, pulses and held value.
    task automatic drain_check(input string name);
        int t;
        t = 0;
        while (rx_q.size() > 0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) check({name, "_drain_timeout"}, 1'b0, rx_q.size(), 0);
        repeat (24) @(posedge clk);
        @(negedge clk);
        check({name, "_pops"}, (pops - pops_mark) == (bytes_sent - bytes_mark),
              pops - pops_mark, bytes_sent - bytes_mark);
        check({name, "_pending_pulses"}, exp_q.size() == 0, exp_q.size(), 0);
        check({name, "_counter"}, int'(bus.counter) == m_committed, int'(bus.counter), m_committed);
`ifdef UART_DEC_ECHO_EN
        check({name, "_pending_echo"}, echo_q.size() == 0, echo_q.size(), 0);
`endif
        pops_mark  = pops;
        bytes_mark = bytes_sent;
    endtask

    // RX FIFO model: pop seen during a cycle takes effect just after the following edge.
    initial begin
        bit popped;
        bus.rx_data  = 8'h00;
        bus.rx_empty = 1'b1;
`ifdef UART_DEC_ECHO_EN
        bus.tx_full  = 1'b0;
`endif
        forever begin
            @(negedge clk);
            popped = bus.rx_pop;
            @(posedge clk);
            #1;
            if (popped) begin
                pops++;
                if (rx_q.size() > 0) begin
                    bus.rx_data = rx_q[0].b;
`ifdef UART_DEC_ECHO_EN
                    echo_q.push_back(rx_q[0].b);
`endif
                    void'(rx_q.pop_front());
                end
            end
            if (rx_q.size() > 0 && rx_q[0].gap > 0) begin
                bus.rx_empty = 1'b1;
                rx_q[0].gap = rx_q[0].gap - 1;
            end else begin
                bus.rx_empty = (rx_q.size() == 0);
            end
`ifdef UART_DEC_ECHO_EN
            bus.tx_full = ($urandom_range(0, 3) == 0);
`endif
        end
    end

    // Monitor: handshake rules every cycle, scoreboard pop on every counter_valid/err pulse.
    initial begin
        bit          prev_pop;
        bit          prev_pulse;
        logic [13:0] prev_counter;
        bit          ok;
        exp_t        e;
        prev_pop     = 1'b0;
        prev_pulse   = 1'b0;
        prev_counter = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ok = !(bus.rx_pop && bus.rx_empty) && !(bus.rx_pop && prev_pop)
                     && !(bus.counter_valid && bus.err)
                     && !((bus.counter_valid || bus.err) && prev_pulse)
                     && (bus.counter_valid || bus.counter == prev_counter);
                check("protocol", ok,
                      int'({bus.rx_pop, bus.rx_empty, prev_pop, bus.counter_valid, bus.err, prev_pulse}),
                      int'(prev_counter));
                if (bus.counter_valid || bus.err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 1'b0, int'({bus.counter_valid, bus.err}), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind_err", bus.err == e.is_err, int'(bus.err), int'(e.is_err));
                        check("pulse_counter", int'(bus.counter) == e.val, int'(bus.counter), e.val);
                    end
                end
`ifdef UART_DEC_ECHO_EN
                if (bus.tx_push) begin
                    if (echo_q.size() == 0) begin
                        check("unexpected_echo", 1'b0, int'(bus.tx_data), 0);
                    end else begin
                        logic [7:0] eb;
                        eb = echo_q.pop_front();
                        check("echo_data", bus.tx_data == eb, int'(bus.tx_data), int'(eb));
                    end
                end
`endif
            end
            prev_pop     = bus.rx_pop;
            prev_pulse   = bus.counter_valid || bus.err;
            prev_counter = bus.counter;
        end
    end

    // Stimulus: test-plan lines first, then random batches.
    initial begin
        logic [7:0] bad_set [4];
        bad_set     = '{8'h61, 8'h2D, 8'h20, 8'h2E};
        rst         = 1'b1;
        m_bad       = 1'b0;
        m_committed = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_counter", bus.counter == 14'd0, int'(bus.counter), 0);
        check("reset_outputs", !bus.counter_valid && !bus.err && !bus.rx_pop,
              int'({bus.counter_valid, bus.err, bus.rx_pop}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_str("1234", 0); send_byte(CR, 0);
        drain_check("l1234_gap0");
        send_str("1234", 7); send_byte(CR, 7);
        drain_check("l1234_gap7");
        send_str("42", 0); send_byte(CR, 0); send_byte(LF, 0);
        send_byte(CR, 2); send_byte(LF, 2);
        drain_check("l42_crlf_blank");
        send_str("1234", 0); send_byte(CR, 0);
        send_str("12345", 1); send_byte(CR, 1);
        drain_check("l12345_overflow");
        send_str("7", 0); send_byte(CR, 0);
        drain_check("l7");
        send_str("12a3", 0); send_byte(CR, 0);
        drain_check("l12a3_bad");
        send_str("0", 0); send_byte(CR, 0);
        drain_check("l0");

        send_str("98", 0);
        drain_check("partial98");
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_digits.delete();
        m_bad       = 1'b0;
        m_committed = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_counter", bus.counter == 14'd0, int'(bus.counter), 0);
        send_str("5", 0); send_byte(CR, 0);
        drain_check("l5_after_reset");

        for (int batch = 0; batch < 25; batch++) begin
            for (int ln = 0; ln < 8; ln++) begin
                int len;
                len = $urandom_range(0, 6);
                for (int k = 0; k < len; k++) begin
                    int g;
                    g = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 2);
                    if ($urandom_range(0, 11) == 0)
                        send_byte(bad_set[$urandom_range(0, 3)], g);
                    else
                        send_byte(8'(8'h30 + $urandom_range(0, 9)), g);
                end
                if ($urandom_range(0, 2) == 0) begin
                    send_byte(CR, 0);
                    send_byte(LF, 0);
                end else begin
                    send_byte(($urandom_range(0, 1) == 0) ? CR : LF, $urandom_range(0, 3));
                end
            end
            drain_check("random_batch");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
